neuron_mac_datapath: RTL and testbench

//  Responder end of the neuron control strobes. Holds the x/weight operand registers and the signed MAC accumulator.

---
 rtl/neuron_pkg.sv | 40 ++++
 rtl/neuron_mac_datapath_if.sv | 19 +
 rtl/neuron_result_fifo.sv | 99 +++++++++
 rtl/neuron_mac_datapath.sv | 169 ++++++++++++++++
 tb/tb_neuron_mac_datapath.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// Shared types and defaults for the neuron MAC datapath.
// Holds the FSM state enum, the default operand/accumulator sizes and the
// saturating add used when the datapath is built with NEURON_SAT_EN.
package neuron_pkg;

  localparam int unsigned DEF_N     = 8;
  localparam int unsigned DEF_D     = 4;
  localparam int unsigned DEF_Q     = 3;
  localparam int unsigned DEF_ACC_W = 20;

  // Working width of sat_add; callers sign-extend into it and truncate back out.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Adds two w-bit signed values held in SAT_W bits and clamps to the w-bit range.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/neuron_mac_datapath_if.sv
// Result stream of the neuron MAC datapath (valid/ready).
//   rd_data  : head of the result FIFO, meaningful only while rd_valid
//   rd_valid : a result is available
//   rd_ready : consumer takes the head this cycle
// master = producing datapath, slave = consumer.
interface neuron_mac_datapath_if
  import neuron_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
);

  logic [ACC_W-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;

  modport master (output rd_data, output rd_valid, input rd_ready);
  modport slave  (input rd_data, input rd_valid, output rd_ready);

endinterface

// File: rtl/neuron_result_fifo.sv
// Q-entry result FIFO with count-based full/empty and same-cycle push/pop.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   clear          : synchronous flush of pointers, count and head register
//   push/push_data : enqueue request (dropped when full unless a pop frees a slot)
//   pop            : dequeue request
//   rd_data        : registered head entry (zero when empty)
//   count          : current occupancy
//   count_next_c   : occupancy after this edge (combinational)
//   drop_c         : push rejected this cycle (combinational)
module neuron_result_fifo
  import neuron_pkg::*;
#(
  parameter int unsigned Q = DEF_Q,
  parameter int unsigned W = DEF_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(Q+1)-1:0] count,
  output logic [$clog2(Q+1)-1:0] count_next_c,
  output logic                   drop_c
);

  localparam int unsigned PTR_W = (Q > 1) ? $clog2(Q) : 1;
  localparam int unsigned CNT_W = $clog2(Q + 1);

  logic [W-1:0]     mem_q [Q];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     rd_data_q, rd_data_d;
  logic             push_ok, pop_ok;

  // Pointer increment that wraps at Q, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(Q - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers/count and the next head value.
  always_comb begin
    pop_ok    = pop && (count_q != '0);
    push_ok   = push && ((count_q != CNT_W'(Q)) || pop_ok);
    drop_c    = push && !push_ok;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    rd_data_d = '0;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      push_ok  = 1'b0;
      drop_c   = 1'b0;
    end else begin
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push_ok) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      // The new head is the incoming word when it lands exactly at the next read slot.
      if (count_d != '0) begin
        rd_data_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? push_data : mem_q[rd_ptr_d];
      end
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      for (int unsigned i = 0; i < Q; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign count        = count_q;
  assign count_next_c = count_d;

endmodule

// File: rtl/neuron_mac_datapath.sv
// Neuron MAC datapath: responder to the neuron sequencer's control strobes.
// Holds x/weight operand registers and a signed accumulator, queues finished
// results in neuron_result_fifo and streams them out over valid/ready.
// Build option: NEURON_SAT_EN makes the accumulate saturate instead of wrap.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   start                         : begin/restart a run (flush FIFO, acc, flags)
//   x_in, w_in, write_x, write_w  : operand loads
//   acc_write, clear_acc          : accumulate x*w / clear accumulator
//   res_write                     : push accumulator into the result FIFO
//   done                          : sequencer finished, drain the FIFO
//   rd                            : result stream (master side)
//   acc_cnt                       : accumulations since last clear, saturates at D
//   res_ovf                       : sticky, a push hit a full FIFO
//   drain_done                    : one-cycle pulse on return to IDLE after a drain
module neuron_mac_datapath
  import neuron_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned D     = DEF_D,
  parameter int unsigned Q     = DEF_Q,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N-1:0]           x_in,
  input  logic [N-1:0]           w_in,
  input  logic                   write_x,
  input  logic                   write_w,
  input  logic                   acc_write,
  input  logic                   res_write,
  input  logic                   clear_acc,
  input  logic                   done,
  neuron_mac_datapath_if.master  rd,
  output logic [$clog2(D+1)-1:0] acc_cnt,
  output logic                   res_ovf,
  output logic                   drain_done
);

  localparam int unsigned CNT_W  = $clog2(D + 1);
  localparam int unsigned QCNT_W = $clog2(Q + 1);

  state_t                  state_q, state_d;
  logic                    drain_done_q, drain_done_d;
  logic                    rd_valid_q, rd_valid_d;
  logic signed [N-1:0]     x_q, w_q;
  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] acc_q, prod_ext, acc_sum;
  logic [CNT_W-1:0]        cnt_q;
  logic                    res_ovf_q;
  logic                    run_act, push, pop;
  logic                    fifo_drop_c;
  logic [QCNT_W-1:0]       fifo_count, fifo_count_next_c;
  logic [ACC_W-1:0]        fifo_rd_data;

  // Datapath strobes act only in RUN; a start in the same cycle wins.
  assign run_act = (state_q == RUN) && !start;
  assign push    = run_act && res_write;
  assign pop     = rd_valid_q && rd.rd_ready && !start;

  assign prod     = x_q * w_q;
  assign prod_ext = ACC_W'(prod);

`ifdef NEURON_SAT_EN
  assign acc_sum = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'(prod_ext), ACC_W));
`else
  assign acc_sum = acc_q + prod_ext;
`endif

  neuron_result_fifo #(
    .Q (Q),
    .W (ACC_W)
  ) u_result_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear        (start),
    .push         (push),
    .pop          (pop),
    .push_data    (acc_q),
    .rd_data      (fifo_rd_data),
    .count        (fifo_count),
    .count_next_c (fifo_count_next_c),
    .drop_c       (fifo_drop_c)
  );

  // Run control: next state, drain pulse and next rd_valid.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (start) begin
          state_d = RUN;
        end else if (done) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (start) begin
          state_d = RUN;
        end else if (fifo_count == '0) begin
          state_d      = IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_valid_d = (state_d != IDLE) && (fifo_count_next_c != '0);
  end

  // Run control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      drain_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Operands, accumulator, accumulation count and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      w_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_ovf_q <= 1'b0;
    end else if (start) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      res_ovf_q <= 1'b0;
    end else if (run_act) begin
      if (write_x) begin
        x_q <= x_in;
      end
      if (write_w) begin
        w_q <= w_in;
      end
      // Clear together with accumulate restarts the sum at the current product.
      if (clear_acc) begin
        acc_q <= acc_write ? prod_ext : '0;
        cnt_q <= acc_write ? CNT_W'(1) : '0;
      end else if (acc_write) begin
        acc_q <= acc_sum;
        cnt_q <= (cnt_q == CNT_W'(D)) ? cnt_q : cnt_q + CNT_W'(1);
      end
      if (fifo_drop_c) begin
        res_ovf_q <= 1'b1;
      end
    end
  end

  assign rd.rd_data  = fifo_rd_data;
  assign rd.rd_valid = rd_valid_q;
  assign acc_cnt     = cnt_q;
  assign res_ovf     = res_ovf_q;
  assign drain_done  = drain_done_q;

endmodule

// File: tb/tb_neuron_mac_datapath.sv
// Directed bench for neuron_mac_datapath: a default-size instance (ACC_W=20)
// and an ACC_W=16 instance share the same stimulus.
module tb_neuron_mac_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, write_x, write_w, acc_write, res_write, clear_acc, done;
  logic [7:0] x_in, w_in;
  logic       rd_ready;
  logic [2:0] acc_cnt, acc_cnt16;
  logic       res_ovf, res_ovf16, drain_done, drain_done16;

  int checks   = 0;
  int failures = 0;

  neuron_mac_datapath_if #(.ACC_W(20)) rd_if ();
  neuron_mac_datapath_if #(.ACC_W(16)) rd_if16 ();

  assign rd_if.rd_ready   = rd_ready;
  assign rd_if16.rd_ready = rd_ready;

  always #5 clk = ~clk;

  neuron_mac_datapath #(.N(8), .D(4), .Q(3), .ACC_W(20)) u_dut (
    .clk (clk), .rst (rst), .start (start), .x_in (x_in), .w_in (w_in),
    .write_x (write_x), .write_w (write_w), .acc_write (acc_write),
    .res_write (res_write), .clear_acc (clear_acc), .done (done),
    .rd (rd_if.master), .acc_cnt (acc_cnt), .res_ovf (res_ovf),
    .drain_done (drain_done)
  );

  neuron_mac_datapath #(.N(8), .D(4), .Q(3), .ACC_W(16)) u_dut16 (
    .clk (clk), .rst (rst), .start (start), .x_in (x_in), .w_in (w_in),
    .write_x (write_x), .write_w (write_w), .acc_write (acc_write),
    .res_write (res_write), .clear_acc (clear_acc), .done (done),
    .rd (rd_if16.master), .acc_cnt (acc_cnt16), .res_ovf (res_ovf16),
    .drain_done (drain_done16)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then strobes drop.
  task automatic tick();
    @(posedge clk);
    #1;
    start = 0; write_x = 0; write_w = 0; acc_write = 0;
    res_write = 0; clear_acc = 0; done = 0;
  endtask

  initial begin
    rst = 1; start = 0; write_x = 0; write_w = 0; acc_write = 0;
    res_write = 0; clear_acc = 0; done = 0; rd_ready = 0;
    x_in = 8'd0; w_in = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", rd_if.rd_valid, 0);
    chk("rst_rd_data", rd_if.rd_data, 0);
    chk("rst_acc_cnt", acc_cnt, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_res_ovf16", res_ovf16, 0);
    chk("rst_drain_done16", drain_done16, 0);
    rst = 0;
    res_write = 1;
    tick();
    chk("idle_push_ignored", rd_if.rd_valid, 0);

    // Basic MAC: 4 x (3 * -2) = -24
    start = 1; tick();
    x_in = 8'd3; w_in = 8'(-2); write_x = 1; write_w = 1; tick();
    repeat (4) begin acc_write = 1; tick(); end
    chk("mac_acc_cnt4", acc_cnt, 4);
    res_write = 1; tick();
    chk("mac_rd_valid", rd_if.rd_valid, 1);
    chk("mac_rd_data", $signed(rd_if.rd_data), -24);
    acc_write = 1; tick();
    chk("acc_cnt_sat", acc_cnt, 4);

    // Clear+accumulate with 5*7, then push/accumulate and push/clear pairs
    x_in = 8'd5; w_in = 8'd7; write_x = 1; write_w = 1; tick();
    clear_acc = 1; acc_write = 1; tick();
    chk("clr_acc_cnt1", acc_cnt, 1);
    res_write = 1; acc_write = 1; tick();          // pushes 35, acc -> 70
    chk("push_acc_cnt2", acc_cnt, 2);
    chk("head_unchanged", $signed(rd_if.rd_data), -24);
    res_write = 1; clear_acc = 1; tick();          // pushes 70, acc -> 0
    chk("push_clr_cnt0", acc_cnt, 0);
    chk("full_no_ovf", res_ovf, 0);

    // Full FIFO, push and pop together: -24 leaves, 35 enters
    acc_write = 1; tick();                         // acc = 35
    res_write = 1; rd_ready = 1; tick();
    rd_ready = 0;
    chk("pushpop_res_ovf", res_ovf, 0);
    chk("pushpop_head", $signed(rd_if.rd_data), 35);
    chk("pushpop_valid", rd_if.rd_valid, 1);

    // Push into a full FIFO: 42 dropped
    x_in = 8'd1; write_x = 1; tick();
    acc_write = 1; tick();                         // acc = 35 + 7 = 42
    res_write = 1; tick();
    chk("ovf_set", res_ovf, 1);
    chk("ovf_head", $signed(rd_if.rd_data), 35);
    rd_ready = 1;
    tick();
    chk("pop_seq_1", $signed(rd_if.rd_data), 70);
    tick();
    chk("pop_seq_2", $signed(rd_if.rd_data), 35);
    tick();
    chk("pop_seq_empty", rd_if.rd_valid, 0);
    rd_ready = 0;
    chk("ovf_sticky", res_ovf, 1);

    // Restart, two results (7, 14), then drain
    start = 1; tick();
    chk("restart_ovf", res_ovf, 0);
    chk("restart_acc_cnt", acc_cnt, 0);
    acc_write = 1; tick();
    res_write = 1; tick();
    acc_write = 1; tick();
    res_write = 1; tick();
    done = 1; tick();
    chk("drain_valid", rd_if.rd_valid, 1);
    chk("drain_head", $signed(rd_if.rd_data), 7);
    chk("drain_pulse_early", drain_done, 0);
    rd_ready = 1; res_write = 1; acc_write = 1; tick();   // datapath strobes ignored in DRAIN
    chk("drain_pop1", $signed(rd_if.rd_data), 14);
    tick();
    chk("drain_empty_valid", rd_if.rd_valid, 0);
    chk("drain_pulse_not_yet", drain_done, 0);
    tick();
    chk("drain_pulse", drain_done, 1);
    chk("drain_acc_cnt", acc_cnt, 2);
    tick();
    chk("drain_pulse_end", drain_done, 0);
    chk("idle_valid", rd_if.rd_valid, 0);
    rd_ready = 0;

    // -128 * -128 three times: 49152 at 20 bits; wraps or saturates at 16 bits
    start = 1; tick();
    x_in = 8'h80; w_in = 8'h80; write_x = 1; write_w = 1; tick();
    repeat (3) begin acc_write = 1; tick(); end
    res_write = 1; tick();
    chk("wide_acc", $signed(rd_if.rd_data), 49152);
`ifdef NEURON_SAT_EN
    chk("acc16_sat", $signed(rd_if16.rd_data), 32767);
`else
    chk("acc16_wrap", $signed(rd_if16.rd_data), -16384);
`endif
    chk("acc16_cnt", acc_cnt16, 3);

    // Reset mid-run with a full, overflowed FIFO
    res_write = 1; tick();
    res_write = 1; tick();
    res_write = 1; tick();
    chk("pre_rst_ovf", res_ovf, 1);
    rst = 1;
    #1;
    chk("rst_mid_valid", rd_if.rd_valid, 0);
    chk("rst_mid_ovf", res_ovf, 0);
    chk("rst_mid_cnt", acc_cnt, 0);
    done = 1; tick();
    chk("rst_no_drain", drain_done, 0);
    rst = 0;
    res_write = 1; tick();
    chk("rst_idle_valid", rd_if.rd_valid, 0);
    chk("rst_idle_no_drain", drain_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
